commit_monitor: RTL and testbench
=================================

Name: commit_monitor

Overview:
- Consumer end of the CPU commit/debug interface. Drives the CPU's global_en, watches the commit_* outputs it produces, and runs the CPU in run, single-step, pause and halt modes.
- Captures every retired instruction into a trace FIFO drained over a valid/ready port. Keeps retired-instruction and enabled-cycle counters.
- Sits between the CPU core and the board/debug-host logic.

Parameters:
- FIFO_DEPTH, 8, trace FIFO entries; power of two, minimum 4.
- START_RUN, 0, reset state: 1 = RUN, 0 = PAUSED.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- run  in  1  pulse: leave PAUSED and enter RUN
- step  in  1  pulse: retire exactly one instruction, then pause
- stop  in  1  pulse: enter PAUSED
- commit  in  1  CPU commit valid (held while the CPU is disabled)
- commit_pc  in  32  retired PC
- commit_inst  in  32  retired instruction
- commit_halt  in  1  retired instruction is the halt instruction (0x80000000)
- commit_reg_we  in  1  register-file write enable of the retired instruction
- commit_reg_wa  in  5  register-file write address
- commit_reg_wd  in  32  register-file write data
- global_en  out  1  CPU enable; registered
- state  out  2  0 = PAUSED, 1 = RUN, 2 = STEP, 3 = HALTED
- instret  out  32  count of retired instructions
- cycles  out  32  count of cycles with global_en high
- trace_valid  out  1  trace FIFO not empty
- trace_ready  in  1  consumer accepts the trace head
- trace_data  out  102  {pc[31:0], inst[31:0], reg_we, reg_wa[4:0], reg_wd[31:0]}, MSB first
- overflow  out  1  sticky flag: a commit record was dropped

Behaviour:
- Reset:
  - State is PAUSED, or RUN if START_RUN = 1.
  - global_en = 0, instret = 0, cycles = 0, FIFO empty, trace_valid = 0, overflow = 0.
- Commit qualification:
  - en_q is global_en registered one cycle.
  - commit_fire = commit & en_q. The CPU holds commit while disabled, so only the first cycle after an enabled cycle counts.
- On commit_fire:
  - Push the record, instret += 1.
  - If the FIFO is full and no pop happens in the same cycle, drop the record and set overflow.
- FIFO:
  - First-word-fall-through.
  - Pop when trace_valid & trace_ready.
  - Push and pop in the same cycle are both allowed, including when the FIFO is full (the pop frees the slot).
- cycles increments on every cycle where global_en = 1.
- Both counters wrap modulo 2^32.
- FSM transitions:
  - PAUSED: stop has priority, then step, then run.
    - step → STEP.
    - run → RUN.
  - RUN:
    - stop → PAUSED.
    - step is ignored.
  - STEP: on commit_fire → PAUSED. stop → PAUSED.
  - Any state except HALTED: commit_fire with commit_halt → HALTED. This beats stop, step and run in the same cycle.
  - HALTED: absorbing; only rst leaves it.
- global_en next value:
  - 1 only if the next state is RUN or STEP and the free FIFO entries after this cycle's push/pop are ≥ 2.
  - Otherwise 0.
  - The ≥ 2 margin covers the one commit already in flight, so backpressure never drops records in normal operation.
- Halt record: pushed and counted like any other commit. global_en is 0 from the next cycle on.
- Draining the trace FIFO below the threshold re-asserts global_en one cycle later while in RUN or STEP.
- rst mid-operation: all state cleared as above; FIFO contents are discarded.

Optional Feature:
- Macro COMMIT_MON_BREAKPOINT_EN.
- Defined:
  - Adds inputs bp_valid (1 bit) and bp_pc (32 bits), and output bp_hit (1-cycle pulse).
  - In RUN or STEP, commit_fire with bp_valid and commit_pc == bp_pc forces PAUSED and pulses bp_hit. The record is still pushed.
  - Halt beats breakpoint when both match the same commit.
- Undefined: the ports are absent and there is no breakpoint logic.

Decomposition:
- Shared package commit_mon_pkg holds:
  - state encodings (PAUSED, RUN, STEP, HALTED);
  - HALT_INST = 32'h80000000;
  - TRACE_W = 102 and the field offsets of the trace record.
- One sub-module, commit_trace_fifo: synchronous FWFT FIFO parameterised by width and depth. It outputs count, full and empty.

Test Plan:
1. Reset, then run; CPU commits 3 non-halt instructions on consecutive enabled cycles → 3 trace records in order, instret = 3, state = 1.
2. From PAUSED, pulse step; commit arrives 5 cycles later → exactly one record; state returns to 0 the cycle after commit_fire; global_en = 0 thereafter; instret = 1.
3. In RUN, commit with commit_inst = 0x80000000 and commit_halt = 1 → record pushed, state = 3, global_en = 0 next cycle; run and step are then ignored.
4. FIFO_DEPTH = 4, trace_ready = 0, continuous commits → global_en drops with 2 entries free; total of 4 records, overflow = 0. Raise trace_ready → global_en reasserts and the records drain in order.
5. commit held high for 4 cycles while global_en = 0 → no push and no instret change.
6. With COMMIT_MON_BREAKPOINT_EN and bp_pc = 0x1C in RUN → commit at 0x1C gives bp_hit pulse, state = 0, record pushed; halt at the breakpoint PC gives state = 3.

Source files
------------

// File: rtl/commit_mon_pkg.sv
// rtl/commit_mon_pkg.sv - shared state encodings, trace record layout and helpers for commit_monitor
package commit_mon_pkg;

    typedef enum logic [1:0] {
        ST_PAUSED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } mon_state_e;

    localparam logic [31:0] HALT_INST = 32'h8000_0000;

    // Trace record layout, MSB first: {pc, inst, reg_we, reg_wa, reg_wd}
    localparam int TRACE_W     = 102;
    localparam int TR_WD_LSB   = 0;
    localparam int TR_WA_LSB   = 32;
    localparam int TR_WE_BIT   = 37;
    localparam int TR_INST_LSB = 38;
    localparam int TR_PC_LSB   = 70;

    function automatic logic [TRACE_W-1:0] pack_trace(
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic        reg_we,
        input logic [4:0]  reg_wa,
        input logic [31:0] reg_wd
    );
        logic [TRACE_W-1:0] rec;
        rec                       = '0;
        rec[TR_PC_LSB   +: 32]    = pc;
        rec[TR_INST_LSB +: 32]    = inst;
        rec[TR_WE_BIT]            = reg_we;
        rec[TR_WA_LSB   +: 5]     = reg_wa;
        rec[TR_WD_LSB   +: 32]    = reg_wd;
        return rec;
    endfunction

endpackage

// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - synchronous first-word-fall-through FIFO with count/full/empty
module commit_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             pop_ok;
    logic             push_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO can still accept a push.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/commit_monitor.sv
// rtl/commit_monitor.sv - CPU commit consumer: run/step/pause/halt control, trace FIFO, counters; breakpoint option under COMMIT_MON_BREAKPOINT_EN
module commit_monitor
    import commit_mon_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter bit START_RUN  = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         step,
    input  logic         stop,
    input  logic         commit,
    input  logic [31:0]  commit_pc,
    input  logic [31:0]  commit_inst,
    input  logic         commit_halt,
    input  logic         commit_reg_we,
    input  logic [4:0]   commit_reg_wa,
    input  logic [31:0]  commit_reg_wd,
    output logic         global_en,
    output logic [1:0]   state,
    output logic [31:0]  instret,
    output logic [31:0]  cycles,
    output logic         trace_valid,
    input  logic         trace_ready,
`ifdef COMMIT_MON_BREAKPOINT_EN
    input  logic         bp_valid,
    input  logic [31:0]  bp_pc,
    output logic         bp_hit,
`endif
    output logic [101:0] trace_data,
    output logic         overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam mon_state_e RESET_STATE = START_RUN ? ST_RUN : ST_PAUSED;

    mon_state_e     state_q, state_d;
    logic           global_en_q, global_en_d;
    logic           en_q;
    logic [31:0]    instret_q;
    logic [31:0]    cycles_q;
    logic           overflow_q;

    logic           commit_fire;
    logic           fifo_pop;
    logic           fifo_push_acc;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  count_nxt;
    logic [TRACE_W-1:0] rec;

`ifdef COMMIT_MON_BREAKPOINT_EN
    logic           bp_hit_q, bp_hit_d;
    assign bp_hit = bp_hit_q;
`endif

    // The CPU holds commit while disabled; only the cycle after an enabled cycle is a real retire.
    assign commit_fire   = commit & en_q;
    assign fifo_pop      = ~fifo_empty & trace_ready;
    assign fifo_push_acc = commit_fire & (~fifo_full | fifo_pop);
    assign count_nxt     = fifo_count + CW'(fifo_push_acc) - CW'(fifo_pop);
    assign rec           = pack_trace(commit_pc, commit_inst, commit_reg_we, commit_reg_wa, commit_reg_wd);

    commit_trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (commit_fire),
        .push_data_i (rec),
        .pop_i       (fifo_pop),
        .head_o      (trace_data),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Next-state selection: halt on a retired halt beats everything, breakpoint beats user pulses.
    always_comb begin
        state_d = state_q;
`ifdef COMMIT_MON_BREAKPOINT_EN
        bp_hit_d = 1'b0;
`endif
        case (state_q)
            ST_PAUSED: begin
                if (stop)      state_d = ST_PAUSED;
                else if (step) state_d = ST_STEP;
                else if (run)  state_d = ST_RUN;
            end
            ST_RUN:    if (stop) state_d = ST_PAUSED;
            ST_STEP:   if (commit_fire || stop) state_d = ST_PAUSED;
            default:   state_d = ST_HALTED;
        endcase
`ifdef COMMIT_MON_BREAKPOINT_EN
        if ((state_q == ST_RUN || state_q == ST_STEP) && commit_fire && bp_valid &&
            (commit_pc == bp_pc)) begin
            state_d  = ST_PAUSED;
            bp_hit_d = 1'b1;
        end
`endif
        if (state_q != ST_HALTED && commit_fire && commit_halt) begin
            state_d = ST_HALTED;
`ifdef COMMIT_MON_BREAKPOINT_EN
            bp_hit_d = 1'b0;
`endif
        end
    end

    // Keep two free slots after this cycle so the commit already in flight always has room.
    assign global_en_d = ((state_d == ST_RUN) || (state_d == ST_STEP)) &&
                         (count_nxt <= CW'(FIFO_DEPTH - 2));

    // Control FSM with registered enable and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            global_en_q <= 1'b0;
            en_q        <= 1'b0;
            instret_q   <= '0;
            cycles_q    <= '0;
            overflow_q  <= 1'b0;
`ifdef COMMIT_MON_BREAKPOINT_EN
            bp_hit_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            global_en_q <= global_en_d;
            en_q        <= global_en_q;
            if (commit_fire) instret_q <= instret_q + 32'd1;
            if (global_en_q) cycles_q  <= cycles_q + 32'd1;
            if (commit_fire && fifo_full && !fifo_pop) overflow_q <= 1'b1;
`ifdef COMMIT_MON_BREAKPOINT_EN
            bp_hit_q    <= bp_hit_d;
`endif
        end
    end

    assign global_en   = global_en_q;
    assign state       = state_q;
    assign instret     = instret_q;
    assign cycles      = cycles_q;
    assign overflow    = overflow_q;
    assign trace_valid = ~fifo_empty;

endmodule

// File: tb/tb_commit_monitor.sv
// tb/tb_commit_monitor.sv - randomized and directed bench for commit_monitor against a queue-based reference model
module tb_commit_monitor;
    import commit_mon_pkg::*;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst, run, step, stop;
    logic         commit, commit_halt, commit_reg_we, trace_ready;
    logic [31:0]  commit_pc, commit_inst, commit_reg_wd;
    logic [4:0]   commit_reg_wa;
    logic         global_en, trace_valid, overflow;
    logic [1:0]   state;
    logic [31:0]  instret, cycles;
    logic [101:0] trace_data;
`ifdef COMMIT_MON_BREAKPOINT_EN
    logic         bp_valid, bp_hit;
    logic [31:0]  bp_pc;
`endif

    commit_monitor #(.FIFO_DEPTH(DEPTH), .START_RUN(1'b0)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .stop(stop),
        .commit(commit), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_halt(commit_halt), .commit_reg_we(commit_reg_we),
        .commit_reg_wa(commit_reg_wa), .commit_reg_wd(commit_reg_wd),
        .global_en(global_en), .state(state), .instret(instret), .cycles(cycles),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
`ifdef COMMIT_MON_BREAKPOINT_EN
        .bp_valid(bp_valid), .bp_pc(bp_pc), .bp_hit(bp_hit),
`endif
        .trace_data(trace_data), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: mode as an integer, trace FIFO as a queue.
    int           m_state;
    bit           m_ge, m_enq, m_ovf, m_bp;
    int unsigned  m_instret, m_cycles;
    logic [101:0] m_q[$];

    task automatic model_reset();
        m_state = 0; m_ge = 0; m_enq = 0; m_ovf = 0; m_bp = 0;
        m_instret = 0; m_cycles = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit fire, hit;
        int ns;
        if (rst) begin
            model_reset();
            return;
        end
        fire = commit && m_enq;
        hit  = 0;
        ns   = m_state;
        case (m_state)
            0: if (!stop) begin
                   if (step) ns = 2;
                   else if (run) ns = 1;
               end
            1: if (stop) ns = 0;
            2: if (fire || stop) ns = 0;
            default: ns = 3;
        endcase
`ifdef COMMIT_MON_BREAKPOINT_EN
        if ((m_state == 1 || m_state == 2) && fire && bp_valid && commit_pc == bp_pc) begin
            ns = 0; hit = 1;
        end
`endif
        if (m_state != 3 && fire && commit_halt) begin
            ns = 3; hit = 0;
        end
        if (m_q.size() > 0 && trace_ready) void'(m_q.pop_front());
        if (fire) begin
            m_instret++;
            if (m_q.size() < DEPTH)
                m_q.push_back({commit_pc, commit_inst, commit_reg_we, commit_reg_wa, commit_reg_wd});
            else
                m_ovf = 1;
        end
        m_cycles += m_ge;
        m_enq = m_ge;
        m_ge  = (ns == 1 || ns == 2) && (DEPTH - m_q.size() >= 2);
        m_state = ns;
        m_bp    = hit;
    endtask

    task automatic check_all();
        check("state", state, m_state[1:0]);
        check("global_en", global_en, m_ge);
        check("instret", instret, m_instret);
        check("cycles", cycles, m_cycles);
        check("trace_valid", trace_valid, m_q.size() > 0);
        check("overflow", overflow, m_ovf);
        if (m_q.size() > 0) check("trace_data", trace_data, m_q[0]);
`ifdef COMMIT_MON_BREAKPOINT_EN
        check("bp_hit", bp_hit, m_bp);
`endif
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        run = 0; step = 0; stop = 0; commit = 0; commit_halt = 0;
        commit_reg_we = 0; commit_reg_wa = '0; commit_reg_wd = '0;
        commit_pc = '0; commit_inst = '0; trace_ready = 0;
`ifdef COMMIT_MON_BREAKPOINT_EN
        bp_valid = 0; bp_pc = '0;
`endif
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic set_commit(input logic [31:0] pc, input logic [31:0] inst, input bit halt);
        commit = 1; commit_pc = pc; commit_inst = inst; commit_halt = halt;
        commit_reg_we = $urandom_range(0, 1); commit_reg_wa = 5'($urandom);
        commit_reg_wd = $urandom;
    endtask

    task automatic pulse_run();
        run = 1; tick(); run = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        do_reset();
        check("reset_state", state, 2'd0);
        check("reset_ge", global_en, 1'b0);
        check("reset_valid", trace_valid, 1'b0);

        // Three consecutive commits in RUN, then drain in order.
        pulse_run();
        tick();
        for (int i = 0; i < 3; i++) begin
            set_commit(32'h100 + 32'(i * 4), 32'h13 + 32'(i), 1'b0);
            tick();
        end
        commit = 0;
        tick();
        check("t1_instret", instret, 32'd3);
        check("t1_state", state, 2'd1);
        trace_ready = 1;
        for (int i = 0; i < 4; i++) tick();
        trace_ready = 0;

        // Single step with a slow commit.
        do_reset();
        step = 1; tick(); step = 0;
        for (int i = 0; i < 4; i++) tick();
        set_commit(32'h200, 32'h33, 1'b0);
        tick();
        commit = 0;
        tick();
        check("t2_state", state, 2'd0);
        check("t2_instret", instret, 32'd1);
        tick();
        check("t2_ge", global_en, 1'b0);

        // Halt instruction retires; later run/step ignored.
        do_reset();
        pulse_run();
        tick();
        set_commit(32'h300, HALT_INST, 1'b1);
        tick();
        commit = 0; commit_halt = 0;
        tick();
        check("t3_state", state, 2'd3);
        check("t3_ge", global_en, 1'b0);
        pulse_run();
        step = 1; tick(); step = 0;
        tick();
        check("t3_absorb", state, 2'd3);

        // Backpressure with depth 4: no drop, then drain.
        do_reset();
        pulse_run();
        for (int i = 0; i < 10; i++) begin
            set_commit(32'h400 + 32'(i * 4), 32'(i), 1'b0);
            tick();
        end
        commit = 0;
        check("t4_ovf", overflow, 1'b0);
        check("t4_instret", instret, 32'd4);
        trace_ready = 1;
        for (int i = 0; i < 8; i++) tick();
        trace_ready = 0;

        // commit held while disabled is not counted.
        do_reset();
        set_commit(32'h500, 32'h1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        commit = 0;
        check("t5_instret", instret, 32'd0);
        check("t5_valid", trace_valid, 1'b0);

`ifdef COMMIT_MON_BREAKPOINT_EN
        do_reset();
        bp_valid = 1; bp_pc = 32'h1C; trace_ready = 1;
        pulse_run();
        tick();
        set_commit(32'h1C, 32'h13, 1'b0);
        tick();
        commit = 0;
        check("t6_bp_hit", bp_hit, 1'b1);
        check("t6_state", state, 2'd0);
        pulse_run();
        tick();
        set_commit(32'h1C, HALT_INST, 1'b1);
        tick();
        commit = 0; commit_halt = 0;
        check("t6_halt", state, 2'd3);
        idle_inputs();
`endif

        // Randomized episodes.
        for (int ep = 0; ep < 20; ep++) begin
            do_reset();
            for (int c = 0; c < 200; c++) begin
                rst  = ($urandom_range(0, 299) == 0);
                run  = ($urandom_range(0, 9) == 0);
                step = ($urandom_range(0, 11) == 0);
                stop = ($urandom_range(0, 19) == 0);
                trace_ready = $urandom_range(0, 1);
                if ($urandom_range(0, 9) < 7) begin
                    if ($urandom_range(0, 99) == 0)
                        set_commit({$urandom_range(0, 63), 2'b00}, HALT_INST, 1'b1);
                    else
                        set_commit({$urandom_range(0, 63), 2'b00}, $urandom, 1'b0);
                end else begin
                    commit = 0; commit_halt = 0;
                end
`ifdef COMMIT_MON_BREAKPOINT_EN
                bp_valid = $urandom_range(0, 1);
                bp_pc    = {$urandom_range(0, 63), 2'b00};
`endif
                tick();
            end
            idle_inputs();
            rst = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
